// File: rtl/control_ventana_conteo_pkg.sv
// Shared definitions for the measurement-window controller: state encoding
// and the window-timer width.
package control_ventana_conteo_pkg;

    typedef logic [1:0] estado_t;

    localparam estado_t EST_IDLE  = 2'd0;
    localparam estado_t EST_CLEAR = 2'd1;
    localparam estado_t EST_GATE  = 2'd2;
    localparam estado_t EST_LATCH = 2'd3;

    // A one-cycle window still needs a 1-bit timer, hence the floor of 1.
    function automatic int ancho_temporizador(input int ciclos);
        int ancho;
        ancho = $clog2(ciclos);
        if (ancho < 1) begin
            ancho = 1;
        end
        return ancho;
    endfunction

endpackage

// File: rtl/contador_digito.sv
// Event counter closed in a loop with the window controller: soft clear,
// increment on prev_tick, and a limit flag on max_tick.
module contador_digito #(
    parameter int N      = 20,
    parameter int LIMITE = 1024
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         soft_reset,
    input  logic         prev_tick,
    output logic [N-1:0] q,
    output logic         max_tick
);

    localparam logic [N-1:0] LIM = N'(LIMITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (soft_reset) begin
            q <= '0;
        end else if (prev_tick) begin
            q <= q + N'(1);
        end
    end

    assign max_tick = (q >= LIM);

endmodule

// File: rtl/control_ventana_conteo_temporizador_ventana.sv
// Window timer: counts up from 0 while enabled and flags the last window
// cycle (count GATE_CYCLES-1) with a one-cycle fin.
module temporizador_ventana
    import control_ventana_conteo_pkg::*;
#(
    parameter int GATE_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic fin
);

    localparam int            W  = ancho_temporizador(GATE_CYCLES);
    localparam logic [W-1:0]  TC = W'(GATE_CYCLES - 1);

    logic [W-1:0] cuenta;

    always_ff @(posedge clk) begin
        if (reset) begin
            cuenta <= '0;
        end else if (clear) begin
            cuenta <= '0;
        end else if (enable && (cuenta != TC)) begin
            cuenta <= cuenta + W'(1);
        end
    end

    assign fin = enable && (cuenta == TC);

endmodule

// File: rtl/control_ventana_conteo.sv
// Measurement-window controller: clears the counter, gates sig_tick into it
// for GATE_CYCLES cycles, then latches count and overflow and pulses done.
//
// state | meaning
// IDLE  | waiting for start or continuous
// CLEAR | counter soft reset, timer and sticky overflow cleared
// GATE  | sig_tick passed to the counter for GATE_CYCLES cycles
// LATCH | final count on cnt_q, captured into result at end of cycle
module control_ventana_conteo
    import control_ventana_conteo_pkg::*;
#(
    parameter int N           = 20,
    parameter int GATE_CYCLES = 50_000_000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         continuous,
    input  logic         sig_tick,
    output logic         cnt_soft_reset,
    output logic         cnt_tick,
    input  logic [N-1:0] cnt_q,
    input  logic         cnt_max,
    output logic [N-1:0] result,
    output logic         overflow,
    output logic         done,
    output logic         busy
);

    estado_t estado;
    estado_t estado_sig;
    logic    en_gate;
    logic    sticky;
    logic    fin;

    always_comb begin
        estado_sig = estado;
        case (estado)
            EST_IDLE:  if (start || continuous) estado_sig = EST_CLEAR;
            EST_CLEAR: estado_sig = EST_GATE;
            EST_GATE:  if (fin) estado_sig = EST_LATCH;
            EST_LATCH: estado_sig = continuous ? EST_CLEAR : EST_IDLE;
            default:   estado_sig = EST_IDLE;
        endcase
    end

    // Decoded state bits are registered from the next state so the counter
    // controls stay glitch-free and cnt_tick is a single AND.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado         <= EST_IDLE;
            busy           <= 1'b0;
            cnt_soft_reset <= 1'b0;
            en_gate        <= 1'b0;
            done           <= 1'b0;
        end else begin
            estado         <= estado_sig;
            busy           <= (estado_sig != EST_IDLE);
            cnt_soft_reset <= (estado_sig == EST_CLEAR);
            en_gate        <= (estado_sig == EST_GATE);
            done           <= (estado == EST_LATCH);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sticky <= 1'b0;
        end else if (estado == EST_CLEAR) begin
            sticky <= 1'b0;
        end else if (((estado == EST_GATE) || (estado == EST_LATCH)) && cnt_max) begin
            sticky <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result   <= '0;
            overflow <= 1'b0;
        end else if (estado == EST_LATCH) begin
            result   <= cnt_q;
            overflow <= sticky | cnt_max;
        end
    end

    assign cnt_tick = sig_tick & en_gate;

    temporizador_ventana #(
        .GATE_CYCLES(GATE_CYCLES)
    ) u_temporizador (
        .clk    (clk),
        .reset  (reset),
        .clear  (estado == EST_CLEAR),
        .enable (en_gate),
        .fin    (fin)
    );

endmodule

// File: doc/control_ventana_conteo.md
# control_ventana_conteo

Measurement-window controller for the `contador_digito` event counter. It clears the counter, gates event ticks into it for a fixed number of clock cycles, then latches the final count and the overflow status into a result register and pulses `done`. It sits between the input-conditioning logic that produces one-cycle event pulses and the display/readout logic. It supports single-shot and back-to-back (continuous) measurement.

## Interface
Parameters:
- `N`, 20: counter and result width; must match the counter instance.
- `GATE_CYCLES`, 50_000_000: length of the counting window in `clk` cycles; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; everything is on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `start`  in  1  request one measurement; sampled only in IDLE.
- `continuous`  in  1  when 1, a new measurement starts immediately after each LATCH.
- `sig_tick`  in  1  one-cycle event pulse, already synchronised and edge-detected.
- `cnt_soft_reset`  out  1  drives the counter's `soft_reset`.
- `cnt_tick`  out  1  drives the counter's `prev_tick`.
- `cnt_q`  in  N  counter `q`.
- `cnt_max`  in  1  counter `max_tick`.
- `result`  out  N  last latched count.
- `overflow`  out  1  1 if `cnt_max` was seen during the last window.
- `done`  out  1  one-cycle pulse when `result`/`overflow` update.
- `busy`  out  1  1 in every state except IDLE.

## Operation
- States: IDLE, CLEAR, GATE, LATCH.
- IDLE:
  - `start`=1 or `continuous`=1 → CLEAR.
- CLEAR, 1 cycle:
  - `cnt_soft_reset`=1.
  - Window timer loads 0.
  - Sticky overflow flag clears.
  - → GATE.
- GATE, exactly `GATE_CYCLES` cycles:
  - `cnt_tick` = `sig_tick` (combinational AND with state==GATE).
  - Timer increments; on terminal value `GATE_CYCLES-1` → LATCH.
- LATCH, 1 cycle:
  - `cnt_tick`=0.
  - `cnt_q` holds the final count here.
  - At the end of the cycle: `result`<=`cnt_q`, `overflow`<=sticky|`cnt_max`, `done`<=1.
  - → CLEAR if `continuous`=1, else IDLE.
- Sticky overflow: set by `cnt_max`=1 in any GATE or LATCH cycle. `result` is not saturated; it holds the raw `cnt_q`.
- Outputs outside CLEAR/GATE: `cnt_soft_reset`=0 and `cnt_tick`=0.
- `start` in any state other than IDLE is ignored (not queued).
- `continuous` dropped mid-run: the current measurement completes, then IDLE.
- `sig_tick` outside GATE is dropped. Events in the CLEAR cycle are lost by design.
- Reset values: state IDLE, timer 0, `result`=0, `overflow`=0, `done`=0, `busy`=0, `cnt_soft_reset`=0, `cnt_tick`=0.
- Reset mid-operation: state returns to IDLE next edge; the previous `result` is discarded (0). The counter is not cleared by this block on reset; the next CLEAR does it.
- Timer width: `$clog2(GATE_CYCLES)`, minimum 1 bit. For `GATE_CYCLES`=1, GATE lasts 1 cycle.

## Timing
Take `start` sampled high at edge 0 in IDLE:
- Cycle 1: CLEAR; the counter holds 0 from the edge ending cycle 1.
- Cycles 2 … `GATE_CYCLES`+1: GATE; each `sig_tick` increments the counter at the end of its cycle.
- Cycle `GATE_CYCLES`+2: LATCH.
- Cycle `GATE_CYCLES`+3: `done`=1, `result`/`overflow` valid and held until the next LATCH.
- Latency from `start` edge to `done`: `GATE_CYCLES`+3 cycles.
- Continuous period: `GATE_CYCLES`+2 cycles. `done` of run k coincides with CLEAR of run k+1.
- `busy`=1 from cycle 1 through LATCH. In continuous mode it stays 1.
- All outputs are registered except `cnt_tick`, which is `sig_tick` gated by a registered state bit (one AND level).

## Structure
- Shared package: state encoding localparams (IDLE=2'd0, CLEAR=2'd1, GATE=2'd2, LATCH=2'd3). Timer-width computation from `GATE_CYCLES`.
- One natural sub-module: `temporizador_ventana`, the window timer.
  - Inputs: `clk`, `reset`, clear, enable.
  - Output: one-cycle `fin` at count `GATE_CYCLES-1`.
  - Parameter: `GATE_CYCLES`.
- The FSM, sticky flag and result registers live in the top module.
- The bench instantiates this block with a real `contador_digito` so the cnt_* loop is closed.

## Test plan
Use `N`=12 and `GATE_CYCLES`=10 unless stated.
- Single shot, `sig_tick` high every cycle → `done` 13 cycles after `start`, `result`=10, `overflow`=0, `busy` falls with `done`.
- Single shot, `sig_tick` every 3rd cycle aligned to the first GATE cycle; also a tick in CLEAR and one right after LATCH → `result`=4, stray ticks not counted.
- `continuous`=1 with 5 ticks per window → `done` every 12 cycles, `result`=5 each time. Drop `continuous` mid-window → one more `done`, then IDLE.
- `GATE_CYCLES`=1200, `sig_tick` always 1 (counter `max_tick` at ≥1024) → `overflow`=1, `result`=1200. Next window with 3 ticks → `overflow`=0, `result`=3.
- `start` pulsed during GATE → ignored, single `done`. `reset` asserted in GATE cycle 5 → next cycle IDLE, `result`=0, `overflow`=0, `done`=0, `cnt_tick`=0. A new `start` then measures correctly.
- `GATE_CYCLES`=1, one tick in the GATE cycle → `result`=1, `done` 4 cycles after `start`.
